// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 (25.175 MHz pixel clock).
package vga_timing_pkg;

  localparam int unsigned DefHAct = 640;
  localparam int unsigned DefHFp  = 16;
  localparam int unsigned DefHPw  = 96;
  localparam int unsigned DefHBp  = 48;

  localparam int unsigned DefVAct = 480;
  localparam int unsigned DefVFp  = 10;
  localparam int unsigned DefVPw  = 2;
  localparam int unsigned DefVBp  = 33;

  localparam int unsigned DefCntW = 10;
  localparam int unsigned DefFrmW = 16;

  // Period of one axis: active region plus front porch, sync and back porch.
  function automatic int unsigned axis_total(input int unsigned act,
                                             input int unsigned fp,
                                             input int unsigned pw,
                                             input int unsigned bp);
    return act + fp + pw + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap flag, registered sync pulse and
// a next-state active-region decode that the parent registers.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACT   = DefHAct,
  parameter int unsigned FP    = DefHFp,
  parameter int unsigned PW    = DefHPw,
  parameter int unsigned BP    = DefHBp,
  parameter bit          POL   = 1'b0,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             advance_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o,
  output logic             sync_o,
  output logic             active_o
);

  localparam int unsigned      Total     = axis_total(ACT, FP, PW, BP);
  localparam logic [CNT_W-1:0] Last      = CNT_W'(Total - 1);
  localparam logic [CNT_W-1:0] SyncFirst = CNT_W'(ACT + FP);
  localparam logic [CNT_W-1:0] SyncLast  = CNT_W'(ACT + FP + PW - 1);
  localparam logic [CNT_W-1:0] ActEnd    = CNT_W'(ACT);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;

  // wrap_o is combinational: the parent needs it before the edge to advance
  // the next axis on that same edge.
  assign wrap_o = (count_q == Last);

  // Next position; sync and active are decoded from it so they line up with
  // the registered count in the same cycle.
  always_comb begin
    count_d = count_q;
    if (advance_i) begin
      count_d = wrap_o ? '0 : count_q + CNT_W'(1);
    end
    sync_d   = ((count_d >= SyncFirst) && (count_d <= SyncLast)) ? POL : ~POL;
    active_o = (count_d < ActEnd);
  end

  // Position and sync registers; reset parks on the last position so the
  // first enabled edge enters position 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= Last;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o = count_q;
  assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync pulses, active-video
// flag and frame/line/vblank strobes, all registered and aligned to adrHor/adrVer.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACT  = DefHAct,
  parameter int unsigned H_FP   = DefHFp,
  parameter int unsigned H_PW   = DefHPw,
  parameter int unsigned H_BP   = DefHBp,
  parameter int unsigned V_ACT  = DefVAct,
  parameter int unsigned V_FP   = DefVFp,
  parameter int unsigned V_PW   = DefVPw,
  parameter int unsigned V_BP   = DefVBp,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0,
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned FRM_W  = DefFrmW
) (
  input  logic             ckVideo,
  input  logic             reset,
  input  logic             ckEn,
  output logic [CNT_W-1:0] adrHor,
  output logic [CNT_W-1:0] adrVer,
  output logic             flgActiveVideo,
  output logic             HS,
  output logic             VS,
  output logic             lineStart,
  output logic             frameStart,
  output logic             vblankStart,
  output logic [FRM_W-1:0] frameCnt
);

  localparam logic [CNT_W-1:0] VLastActive = CNT_W'(V_ACT - 1);

  logic h_wrap, v_wrap, h_active_nxt, v_active_nxt, v_advance;

  logic             active_q, active_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             vblank_q, vblank_d;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;

  assign v_advance = ckEn & h_wrap;

  vga_axis_counter #(
    .ACT   (H_ACT),
    .FP    (H_FP),
    .PW    (H_PW),
    .BP    (H_BP),
    .POL   (HS_POL),
    .CNT_W (CNT_W)
  ) u_hor (
    .clk_i     (ckVideo),
    .rst_i     (reset),
    .advance_i (ckEn),
    .count_o   (adrHor),
    .wrap_o    (h_wrap),
    .sync_o    (HS),
    .active_o  (h_active_nxt)
  );

  vga_axis_counter #(
    .ACT   (V_ACT),
    .FP    (V_FP),
    .PW    (V_PW),
    .BP    (V_BP),
    .POL   (VS_POL),
    .CNT_W (CNT_W)
  ) u_ver (
    .clk_i     (ckVideo),
    .rst_i     (reset),
    .advance_i (v_advance),
    .count_o   (adrVer),
    .wrap_o    (v_wrap),
    .sync_o    (VS),
    .active_o  (v_active_nxt)
  );

  // Strobes fire on the edge that enters the event position; with ckEn low
  // nothing is entered, so they drop after one cycle on their own.
  always_comb begin
    active_d  = h_active_nxt & v_active_nxt;
    line_d    = v_advance;
    frame_d   = v_advance & v_wrap;
    vblank_d  = v_advance & (adrVer == VLastActive);
    frm_cnt_d = frame_d ? frm_cnt_q + FRM_W'(1) : frm_cnt_q;
  end

  // Output registers for the active flag, strobes and frame counter.
  always_ff @(posedge ckVideo) begin
    if (reset) begin
      active_q  <= 1'b0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      vblank_q  <= 1'b0;
      frm_cnt_q <= '0;
    end else begin
      active_q  <= active_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      vblank_q  <= vblank_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  assign flgActiveVideo = active_q;
  assign lineStart      = line_q;
  assign frameStart     = frame_q;
  assign vblankStart    = vblank_q;
  assign frameCnt       = frm_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 mode, an 800x600
// positive-sync mode and a tiny mode that makes whole-frame runs cheap.
module tb_vga_timing_gen;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic ck_en = 1'b0;

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Default mode
  logic [9:0]  d_hor, d_ver;
  logic        d_act, d_hs, d_vs, d_ls, d_fs, d_vb;
  logic [15:0] d_frm;
  // 800x600, positive syncs
  logic [10:0] a_hor, a_ver;
  logic        a_act, a_hs, a_vs, a_ls, a_fs, a_vb;
  logic [15:0] a_frm;
  // Tiny mode: H 8/2/3/2 (15), V 6/1/2/3 (12), 3-bit frame counter
  logic [3:0]  s_hor, s_ver;
  logic        s_act, s_hs, s_vs, s_ls, s_fs, s_vb;
  logic [2:0]  s_frm;

  vga_timing_gen u_dut (
    .ckVideo(clk), .reset(reset), .ckEn(ck_en), .adrHor(d_hor), .adrVer(d_ver),
    .flgActiveVideo(d_act), .HS(d_hs), .VS(d_vs), .lineStart(d_ls), .frameStart(d_fs),
    .vblankStart(d_vb), .frameCnt(d_frm)
  );

  vga_timing_gen #(
    .H_ACT(800), .H_FP(40), .H_PW(128), .H_BP(88), .V_ACT(600), .V_FP(1), .V_PW(4),
    .V_BP(23), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11), .FRM_W(16)
  ) u_alt (
    .ckVideo(clk), .reset(reset), .ckEn(ck_en), .adrHor(a_hor), .adrVer(a_ver),
    .flgActiveVideo(a_act), .HS(a_hs), .VS(a_vs), .lineStart(a_ls), .frameStart(a_fs),
    .vblankStart(a_vb), .frameCnt(a_frm)
  );

  vga_timing_gen #(
    .H_ACT(8), .H_FP(2), .H_PW(3), .H_BP(2), .V_ACT(6), .V_FP(1), .V_PW(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(4), .FRM_W(3)
  ) u_small (
    .ckVideo(clk), .reset(reset), .ckEn(ck_en), .adrHor(s_hor), .adrVer(s_ver),
    .flgActiveVideo(s_act), .HS(s_hs), .VS(s_vs), .lineStart(s_ls), .frameStart(s_fs),
    .vblankStart(s_vb), .frameCnt(s_frm)
  );

  // Packed views: {hor, ver, act, hs, vs, ls, fs, vb, frm}
  logic [41:0] d_got;
  logic [43:0] a_got;
  logic [16:0] s_got;
  assign d_got = {d_hor, d_ver, d_act, d_hs, d_vs, d_ls, d_fs, d_vb, d_frm};
  assign a_got = {a_hor, a_ver, a_act, a_hs, a_vs, a_ls, a_fs, a_vb, a_frm};
  assign s_got = {s_hor, s_ver, s_act, s_hs, s_vs, s_ls, s_fs, s_vb, s_frm};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset held, then released with ckEn high: all DUTs now sit at (0,0).
  task automatic restart();
    reset = 1'b1;
    ck_en = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [41:0] de;
    logic [43:0] ae;
    logic [16:0] se;
    reset = 1'b1;
    ck_en = 1'b1;
    step();
    step();
    de = {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 3'b000, 16'd0};
    ae = {11'd1055, 11'd627, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0};
    se = {4'd14, 4'd11, 1'b0, 1'b1, 1'b1, 3'b000, 3'd0};
    vectors++;
    if (d_got !== de) begin
      miscompares++;
      $display("FAIL reset_dflt got=%h exp=%h", d_got, de);
    end
    vectors++;
    if (a_got !== ae) begin
      miscompares++;
      $display("FAIL reset_alt got=%h exp=%h", a_got, ae);
    end
    vectors++;
    if (s_got !== se) begin
      miscompares++;
      $display("FAIL reset_small got=%h exp=%h", s_got, se);
    end
  endtask

  task automatic test_first_edge();
    logic [41:0] de;
    logic [43:0] ae;
    reset = 1'b0;
    step();
    de = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
    ae = {11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    vectors++;
    if (d_got !== de) begin
      miscompares++;
      $display("FAIL first_edge_dflt got=%h exp=%h", d_got, de);
    end
    vectors++;
    if (a_got !== ae) begin
      miscompares++;
      $display("FAIL first_edge_alt got=%h exp=%h", a_got, ae);
    end
  endtask

  // Three default lines from (0,0); the alt mode runs alongside.
  task automatic test_line_scan();
    logic [41:0] de;
    logic [43:0] ae;
    int h, v, ah, av;
    int hs_low = 0;
    int a_hs_high = 0;
    int ls_cnt = 0;
    for (int i = 1; i <= 2400; i++) begin
      step();
      h  = i % 800;
      v  = i / 800;
      ah = i % 1056;
      av = i / 1056;
      de = {10'(h), 10'(v), 1'(h < 640), 1'(!(h >= 656 && h <= 751)), 1'b1, 1'(h == 0),
            1'b0, 1'b0, 16'd1};
      ae = {11'(ah), 11'(av), 1'(ah < 800), 1'(ah >= 840 && ah <= 967), 1'b0, 1'(ah == 0),
            1'b0, 1'b0, 16'd1};
      vectors++;
      if (d_got !== de) begin
        miscompares++;
        $display("FAIL line_scan_dflt i=%0d got=%h exp=%h", i, d_got, de);
      end
      vectors++;
      if (a_got !== ae) begin
        miscompares++;
        $display("FAIL line_scan_alt i=%0d got=%h exp=%h", i, a_got, ae);
      end
      if (i >= 800 && i < 1600 && d_hs == 1'b0) hs_low++;
      if (i >= 1056 && i < 2112 && a_hs == 1'b1) a_hs_high++;
      if (d_ls == 1'b1) ls_cnt++;
    end
    vectors++;
    if (hs_low != 96) begin
      miscompares++;
      $display("FAIL hs_width_dflt got=%0d exp=96", hs_low);
    end
    vectors++;
    if (a_hs_high != 128) begin
      miscompares++;
      $display("FAIL hs_width_alt got=%0d exp=128", a_hs_high);
    end
    vectors++;
    if (ls_cnt != 3) begin
      miscompares++;
      $display("FAIL line_start_count got=%0d exp=3", ls_cnt);
    end
  endtask

  // Nine tiny frames: VS, vblank, vertical wrap and frame-counter wrap at 8.
  task automatic test_frame_scan();
    logic [16:0] se;
    int sh, sv, frm;
    int vs_low = 0;
    restart();
    for (int i = 1; i <= 9 * 180; i++) begin
      step();
      sh  = i % 15;
      sv  = (i / 15) % 12;
      frm = (1 + i / 180) % 8;
      se = {4'(sh), 4'(sv), 1'(sh < 8 && sv < 6), 1'(!(sh >= 10 && sh <= 12)),
            1'(!(sv >= 7 && sv <= 8)), 1'(sh == 0), 1'(sh == 0 && sv == 0),
            1'(sh == 0 && sv == 6), 3'(frm)};
      vectors++;
      if (s_got !== se) begin
        miscompares++;
        $display("FAIL frame_scan_small i=%0d got=%h exp=%h", i, s_got, se);
      end
      if (i < 180 && s_vs == 1'b0) vs_low++;
    end
    vectors++;
    if (vs_low != 30) begin
      miscompares++;
      $display("FAIL vs_width_small got=%0d exp=30", vs_low);
    end
  endtask

  // ckEn high on every other edge: half-rate advance, strobes still one cycle.
  task automatic test_ck_en_half();
    logic [41:0] de;
    int pos = 0;
    int h, v;
    restart();
    for (int c = 0; c < 1800; c++) begin
      ck_en = (c % 2 == 1);
      step();
      if (ck_en) pos++;
      h = pos % 800;
      v = pos / 800;
      de = {10'(h), 10'(v), 1'(h < 640), 1'(!(h >= 656 && h <= 751)), 1'b1,
            1'(ck_en && h == 0), 1'b0, 1'b0, 16'd1};
      vectors++;
      if (d_got !== de) begin
        miscompares++;
        $display("FAIL ck_en_half c=%0d got=%h exp=%h", c, d_got, de);
      end
    end
    ck_en = 1'b1;
  endtask

  // Hold with ckEn low mid-line, then reset mid-frame (even with ckEn low).
  task automatic test_hold_and_reset();
    logic [41:0] de;
    restart();
    for (int i = 0; i < 1900; i++) step();
    de = {10'd300, 10'd2, 1'b1, 1'b1, 1'b1, 3'b000, 16'd1};
    vectors++;
    if (d_got !== de) begin
      miscompares++;
      $display("FAIL mid_position got=%h exp=%h", d_got, de);
    end
    ck_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (d_got !== de) begin
        miscompares++;
        $display("FAIL hold i=%0d got=%h exp=%h", i, d_got, de);
      end
    end
    reset = 1'b1;
    step();
    de = {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 3'b000, 16'd0};
    vectors++;
    if (d_got !== de) begin
      miscompares++;
      $display("FAIL mid_reset got=%h exp=%h", d_got, de);
    end
    reset = 1'b0;
    ck_en = 1'b1;
    step();
    de = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
    vectors++;
    if (d_got !== de) begin
      miscompares++;
      $display("FAIL reset_release got=%h exp=%h", d_got, de);
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_line_scan();
    test_frame_scan();
    test_ck_en_half();
    test_hold_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
